// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam int unsigned DMEM_DEPTH = 1024;
    localparam int unsigned DATA_W     = 16;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 16 storage with one write port and one registered read port, both on negedge clk.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = DMEM_DEPTH
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] widx,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] ridx,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(negedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
        if (re) begin
            rdata <= mem[ridx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for CPU LW/SW over valid/ready handshakes, with wait states.
// Optional access counters (rd_count/wr_count/err_count) when DMEM_STATS_EN is defined.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH       = DMEM_DEPTH,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [15:0]       req_addr,
    input  logic [15:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [15:0]       rsp_rdata,
    output logic              rsp_err
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
    output logic [15:0]       err_count
`endif
);

    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

    state_t             state, state_next;
    logic [3:0]         cnt, cnt_next;
    logic               accept, enter_resp;
    logic               req_err;
    logic [31:0]        word_idx;
    logic               cap_write, cap_err, rsp_is_read;
    logic [IDX_W-1:0]   cap_idx;
    logic [DATA_W-1:0]  cap_wdata;
    logic [DATA_W-1:0]  arr_rdata;

    assign word_idx  = {17'b0, req_addr[15:1]};
    assign req_err   = req_addr[0] | (word_idx >= 32'(DEPTH));
    assign req_ready = (state == IDLE);
    assign rsp_rdata = rsp_is_read ? arr_rdata : '0;

    // Counter runs down to zero (not one) so a response lands WAIT_CYCLES+1 edges after accept.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    cnt_next   = WAIT_LD;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    enter_resp = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            cap_write   <= 1'b0;
            cap_err     <= 1'b0;
            cap_idx     <= '0;
            cap_wdata   <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_is_read <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                cap_write <= req_write;
                cap_err   <= req_err;
                cap_idx   <= req_addr[IDX_W:1];
                cap_wdata <= req_wdata;
            end
            if (enter_resp) begin
                rsp_valid   <= 1'b1;
                rsp_err     <= cap_err;
                rsp_is_read <= ~cap_write & ~cap_err;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid   <= 1'b0;
                rsp_err     <= 1'b0;
                rsp_is_read <= 1'b0;
            end
        end
    end

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (enter_resp & cap_write & ~cap_err),
        .widx  (cap_idx),
        .wdata (cap_wdata),
        .re    (enter_resp & ~cap_write & ~cap_err),
        .ridx  (cap_idx),
        .rdata (arr_rdata)
    );

`ifdef DMEM_STATS_EN
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count  <= '0;
            wr_count  <= '0;
            err_count <= '0;
        end else if (enter_resp) begin
            if (cap_err) begin
                if (err_count != '1) err_count <= err_count + 16'd1;
            end else if (cap_write) begin
                if (wr_count != '1) wr_count <= wr_count + 16'd1;
            end else begin
                if (rd_count != '1) rd_count <= rd_count + 16'd1;
            end
        end
    end
`endif

endmodule
